upcounter_timer: RTL and testbench

Programmable up-counting timer. It is the count-up counterpart of the team's 4-bit down counter. Once started, it counts from 0 to a latched terminal value, optionally slowed by a prescaler. At terminal it emits a one-cycle done pulse, then either stops (one-shot) or wraps to 0 and repeats (periodic). It is the event/interval generator that control FSMs and testbenches in the design use for delays and periodic strobes.

---
 rtl/upcounter_timer_if.sv | 25 ++
 rtl/upcounter_timer.sv | 87 ++++++++
 tb/tb_upcounter_timer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/upcounter_timer_if.sv
// Control/status bundle for upcounter_timer: the requester drives start/stop/config,
// the timer returns count, busy and the done pulse.
interface upcounter_timer_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
);
  logic                  start;
  logic                  stop;
  logic                  periodic;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  done;

  modport master (
    output start, stop, periodic, limit, prescale,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, periodic, limit, prescale,
    output count, busy, done
  );
endinterface

// File: rtl/upcounter_timer.sv
// Programmable up-counting timer: counts 0..limit at one step per prescale+1 clocks,
// pulses done at terminal, then stops (one-shot) or wraps to 0 (periodic).
module upcounter_timer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input logic              clk,
  input logic              rst,
  upcounter_timer_if.slave tif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [WIDTH-1:0]      count_r;
  logic                  busy_r;
  logic                  done_r;
  logic [PRESCALE_W-1:0] psc;
  logic [WIDTH-1:0]      limit_l;
  logic [PRESCALE_W-1:0] prescale_l;
  logic                  periodic_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      psc        <= '0;
      limit_l    <= '0;
      prescale_l <= '0;
      periodic_l <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (tif.start && !tif.stop) begin
            limit_l    <= tif.limit;
            prescale_l <= tif.prescale;
            periodic_l <= tif.periodic;
            count_r    <= '0;
            psc        <= '0;
            state      <= RUN;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          if (tif.stop) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (tif.start) begin
            limit_l    <= tif.limit;
            prescale_l <= tif.prescale;
            periodic_l <= tif.periodic;
            count_r    <= '0;
            psc        <= '0;
          end else if (psc == prescale_l) begin
            // tick: prescaler wraps; count either advances or hits terminal
            psc <= '0;
            if (count_r == limit_l) begin
              done_r <= 1'b1;
              if (periodic_l) begin
                count_r <= '0;
              end else begin
                state  <= IDLE;
                busy_r <= 1'b0;
              end
            end else begin
              count_r <= count_r + 1'b1;
            end
          end else begin
            psc <= psc + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign tif.count = count_r;
  assign tif.busy  = busy_r;
  assign tif.done  = done_r;

endmodule

// File: tb/tb_upcounter_timer.sv
// Scoreboard bench for upcounter_timer: stimulus pushes hand-computed {count,busy,done}
// for each edge; a monitor pops and compares just after every rising edge.
module tb_upcounter_timer;

  logic clk;
  logic rst;

  upcounter_timer_if #(.WIDTH(4), .PRESCALE_W(4)) tif ();

  upcounter_timer #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  typedef struct {
    string      nm;
    logic [5:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b, expected count=%0d busy=%0b done=%0b",
               nm, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // One edge of stimulus plus the expected outputs right after that edge.
  task automatic step(input string nm, input logic st, input logic sp, input logic per,
                      input logic [3:0] lim, input logic [3:0] ps,
                      input logic [3:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    tif.start    = st;
    tif.stop     = sp;
    tif.periodic = per;
    tif.limit    = lim;
    tif.prescale = ps;
    e.nm = nm;
    e.v  = {ec, eb, ed};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.nm, {tif.count, tif.busy, tif.done}, e.v);
      end
    end
  end

  initial begin : stim
    total = 0;
    bad   = 0;
    rst          = 1'b0;
    tif.start    = 1'b0;
    tif.stop     = 1'b0;
    tif.periodic = 1'b0;
    tif.limit    = 4'd0;
    tif.prescale = 4'd0;

    // 1: async reset without a clock edge, then idle edges
    #3 rst = 1'b1;
    #1 check("reset_async", {tif.count, tif.busy, tif.done}, 6'b0000_0_0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle_hold", 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);

    // 2: one-shot limit=5; input changes during RUN must be ignored
    step("os_start", 1, 0, 0, 4'd5, 4'd0, 4'd0, 1, 0);
    for (int k = 1; k <= 5; k++)
      step("os_count", 0, 0, 1, 4'd1, 4'd3, 4'(k), 1, 0);
    step("os_done", 0, 0, 0, 4'd1, 4'd0, 4'd5, 0, 1);
    step("os_hold", 0, 0, 0, 4'd1, 4'd0, 4'd5, 0, 0);

    // 3: periodic limit=15, three periods
    step("per_start", 1, 0, 1, 4'd15, 4'd0, 4'd0, 1, 0);
    for (int k = 1; k <= 48; k++)
      step("per_run", 0, 0, 0, 4'd0, 4'd0, 4'(k % 16), 1, (k % 16) == 0);
    step("per_stop", 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0);

    // 4: prescale=2, limit=3 one-shot: done 12 edges after start
    step("psc_start", 1, 0, 0, 4'd3, 4'd2, 4'd0, 1, 0);
    for (int k = 1; k <= 12; k++)
      step("psc_run", 0, 0, 0, 4'd0, 4'd0, (k == 12) ? 4'd3 : 4'(k / 3), k != 12, k == 12);
    step("psc_after", 0, 0, 0, 4'd0, 4'd0, 4'd3, 0, 0);

    // 5: stop, start+stop priority, restart
    step("stp_start", 1, 0, 0, 4'd5, 4'd0, 4'd0, 1, 0);
    step("stp_c1", 0, 0, 0, 4'd5, 4'd0, 4'd1, 1, 0);
    step("stp_c2", 0, 0, 0, 4'd5, 4'd0, 4'd2, 1, 0);
    step("stp_stop", 0, 1, 0, 4'd5, 4'd0, 4'd2, 0, 0);
    step("stp_both_idle", 1, 1, 0, 4'd5, 4'd0, 4'd2, 0, 0);
    step("rs_start", 1, 0, 0, 4'd5, 4'd0, 4'd0, 1, 0);
    for (int k = 1; k <= 3; k++) step("rs_count", 0, 0, 0, 4'd5, 4'd0, 4'(k), 1, 0);
    step("rs_restart", 1, 0, 0, 4'd5, 4'd0, 4'd0, 1, 0);
    step("rs_c1", 0, 0, 0, 4'd5, 4'd0, 4'd1, 1, 0);
    step("rs_c2", 0, 0, 0, 4'd5, 4'd0, 4'd2, 1, 0);
    step("rs_stop", 0, 1, 0, 4'd5, 4'd0, 4'd2, 0, 0);

    // 6: async reset mid-RUN, then a clean short run
    step("ar_start", 1, 0, 0, 4'd7, 4'd0, 4'd0, 1, 0);
    for (int k = 1; k <= 4; k++) step("ar_count", 0, 0, 0, 4'd7, 4'd0, 4'(k), 1, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("ar_reset", {tif.count, tif.busy, tif.done}, 6'b0000_0_0);
    @(negedge clk);
    rst = 1'b0;
    step("ar2_start", 1, 0, 0, 4'd2, 4'd0, 4'd0, 1, 0);
    step("ar2_c1", 0, 0, 0, 4'd2, 4'd0, 4'd1, 1, 0);
    step("ar2_c2", 0, 0, 0, 4'd2, 4'd0, 4'd2, 1, 0);
    step("ar2_done", 0, 0, 0, 4'd2, 4'd0, 4'd2, 0, 1);
    step("ar2_after", 0, 0, 0, 4'd2, 4'd0, 4'd2, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
